// File: rtl/div_unit_pkg.sv
// Shared types for the execute-stage divide handshake and the divider state record.
// Holds the divider FSM state, register record and its reset value.
package wires;

    localparam int XLEN = 32;
    localparam int CW   = $clog2(XLEN);

    typedef enum logic [1:0] {
        divs = 2'd0,
        divu = 2'd1,
        rem  = 2'd2,
        remu = 2'd3
    } div_op_type;

    typedef struct packed {
        logic             enable;
        div_op_type       op;
        logic [XLEN-1:0]  rdata1;
        logic [XLEN-1:0]  rdata2;
    } div_in_type;

    typedef struct packed {
        logic             ready;
        logic [XLEN-1:0]  result;
    } div_out_type;

    localparam div_in_type init_div_op = '{
        enable: 1'b0,
        op:     divs,
        rdata1: {XLEN{1'b0}},
        rdata2: {XLEN{1'b0}}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_type;

    typedef struct packed {
        div_state_type    state;
        logic [CW-1:0]    counter;
        div_op_type       op;
        logic             negq;
        logic             negr;
        logic [XLEN-1:0]  divisor;
        logic [XLEN-1:0]  quo;
        logic [XLEN:0]    rem;
        logic [XLEN-1:0]  result;
        logic             ready;
    } div_reg_type;

    localparam div_reg_type init_div_reg = '{
        state:   IDLE,
        counter: {CW{1'b0}},
        op:      divs,
        negq:    1'b0,
        negr:    1'b0,
        divisor: {XLEN{1'b0}},
        quo:     {XLEN{1'b0}},
        rem:     {(XLEN+1){1'b0}},
        result:  {XLEN{1'b0}},
        ready:   1'b0
    };

    function automatic logic is_signed_op(input div_op_type op);
        return (op == divs) || (op == rem);
    endfunction

    function automatic logic is_div_op(input div_op_type op);
        return (op == divs) || (op == divu);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Divide handshake between the execute stage (master) and the divider (slave).
interface div_unit_if;
    import wires::*;

    div_in_type  div_in;
    div_out_type div_out;

    modport master (output div_in, input div_out);
    modport slave  (input div_in, output div_out);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: trivial cases (zero divisor, overflow, |divisor|>|dividend|) finish in one cycle.
module div_unit
    import wires::*;
(
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    div_reg_type r;
    div_reg_type rin;
    div_reg_type v;

    logic            signed_op_s;
    logic            sgn1_s;
    logic            sgn2_s;
    logic [XLEN-1:0] mag1_s;
    logic [XLEN-1:0] mag2_s;
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN:0]   step_rem_s;
    logic [XLEN-1:0] step_quo_s;
    logic [XLEN-1:0] q_s;
    logic [XLEN-1:0] rr_s;

    assign signed_op_s = is_signed_op(bus.div_in.op);
    assign sgn1_s      = signed_op_s & bus.div_in.rdata1[XLEN-1];
    assign sgn2_s      = signed_op_s & bus.div_in.rdata2[XLEN-1];
    assign mag1_s      = sgn1_s ? -bus.div_in.rdata1 : bus.div_in.rdata1;
    assign mag2_s      = sgn2_s ? -bus.div_in.rdata2 : bus.div_in.rdata2;

`ifdef DIV_EARLY_OUT_EN
    logic            early_s;
    logic [XLEN-1:0] early_result_s;

    // Detects operations whose architectural result is known without iterating.
    always_comb begin
        early_s        = 1'b0;
        early_result_s = {XLEN{1'b0}};
        if (bus.div_in.rdata2 == {XLEN{1'b0}}) begin
            early_s        = 1'b1;
            early_result_s = is_div_op(bus.div_in.op) ? {XLEN{1'b1}} : bus.div_in.rdata1;
        end else if (signed_op_s && (bus.div_in.rdata1 == 32'h8000_0000)
                     && (bus.div_in.rdata2 == 32'hFFFF_FFFF)) begin
            early_s        = 1'b1;
            early_result_s = is_div_op(bus.div_in.op) ? 32'h8000_0000 : 32'h0000_0000;
        end else if (mag2_s > mag1_s) begin
            // Remainder keeps the dividend's sign, so the raw dividend is already correct.
            early_s        = 1'b1;
            early_result_s = is_div_op(bus.div_in.op) ? {XLEN{1'b0}} : bus.div_in.rdata1;
        end else begin
            early_s        = 1'b0;
        end
    end
`endif

    // Next-state logic: operand capture, one restoring step per cycle, sign fix-up.
    always_comb begin
        v       = r;
        v.ready = 1'b0;

        rem_shift_s = {r.rem[XLEN-1:0], r.quo[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, r.divisor};
        if (rem_shift_s >= {1'b0, r.divisor}) begin
            step_rem_s = diff_s;
            step_quo_s = {r.quo[XLEN-2:0], 1'b1};
        end else begin
            step_rem_s = rem_shift_s;
            step_quo_s = {r.quo[XLEN-2:0], 1'b0};
        end
        q_s  = r.negq ? -step_quo_s : step_quo_s;
        rr_s = r.negr ? -step_rem_s[XLEN-1:0] : step_rem_s[XLEN-1:0];

        case (r.state)
            IDLE: begin
                if (bus.div_in.enable) begin
                    v.state   = BUSY;
                    v.op      = bus.div_in.op;
                    // A zero divisor must leave the all-ones quotient untouched.
                    v.negq    = (sgn1_s ^ sgn2_s) & (bus.div_in.rdata2 != {XLEN{1'b0}});
                    v.negr    = sgn1_s;
                    v.divisor = mag2_s;
                    v.quo     = mag1_s;
                    v.rem     = {(XLEN+1){1'b0}};
                    v.counter = CW'(XLEN-1);
`ifdef DIV_EARLY_OUT_EN
                    if (early_s) begin
                        v.state  = DONE;
                        v.ready  = 1'b1;
                        v.result = early_result_s;
                    end else begin
                        v.state  = BUSY;
                    end
`endif
                end else begin
                    v.state = IDLE;
                end
            end
            BUSY: begin
                if (!bus.div_in.enable) begin
                    v.state = IDLE;
                end else begin
                    v.rem = step_rem_s;
                    v.quo = step_quo_s;
                    if (r.counter == {CW{1'b0}}) begin
                        v.state  = DONE;
                        v.ready  = 1'b1;
                        v.result = is_div_op(r.op) ? q_s : rr_s;
                    end else begin
                        v.counter = r.counter - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                v.state = IDLE;
            end
            default: begin
                v = init_div_reg;
            end
        endcase

        rin = v;
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= init_div_reg;
        end else begin
            r <= rin;
        end
    end

    assign bus.div_out.ready  = r.ready;
    assign bus.div_out.result = r.result;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, special cases, abort and reset.
module tb_div_unit;
    import wires::*;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    div_unit_if bus();

    div_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_BUILD = 1'b1;
`else
    localparam bit EARLY_BUILD = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Issue one divide, wait for ready, check latency/result and single-cycle ready.
    task automatic run_op(input string tag, input div_op_type op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input bit early_vec, input bit scramble);
        int k;
        int exp_lat;
        k       = 0;
        exp_lat = (EARLY_BUILD && early_vec) ? 1 : 33;
        @(negedge clk);
        bus.div_in.enable = 1'b1;
        bus.div_in.op     = op;
        bus.div_in.rdata1 = a;
        bus.div_in.rdata2 = b;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.div_out.ready === 1'b1) begin
                k = i;
                break;
            end
            if (scramble && (i == 5)) begin
                bus.div_in.rdata1 = 32'hDEAD_BEEF;
                bus.div_in.rdata2 = 32'h0000_0001;
            end
        end
        check_eq({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check_eq({tag, "_res"}, bus.div_out.result, exp);
        bus.div_in.enable = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rdy1"}, {31'd0, bus.div_out.ready}, 32'd0);
    endtask

    initial begin
        int rdy_cnt;
        bus.div_in = init_div_op;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready",  {31'd0, bus.div_out.ready}, 32'd0);
        check_eq("rst_result", bus.div_out.result, 32'd0);
        rst = 1'b1;

        run_op("divu_100_7",  divu, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0);
        run_op("remu_100_7",  remu, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0);
        run_op("divs_m7_2",   divs, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0);
        run_op("rem_m7_2",    rem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0);
        run_op("divs_7_m2",   divs, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 1'b0);
        run_op("rem_7_m2",    rem,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0);
        run_op("divu_5_0",    divu, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op("remu_5_0",    remu, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0);
        run_op("divs_m5_0",   divs, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op("rem_m5_0",    rem,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, 1'b0);
        run_op("divs_ovf",    divs, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b0);
        run_op("rem_ovf",     rem,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0);
        run_op("divu_3_10",   divu, 32'd3,          32'd10,         32'd0,          1'b1, 1'b0);
        run_op("remu_3_10",   remu, 32'd3,          32'd10,         32'd3,          1'b1, 1'b0);
        run_op("rem_m16_32",  rem,  32'hFFFF_FFF0,  32'd32,         32'hFFFF_FFF0,  1'b1, 1'b0);
        run_op("divu_max_16", divu, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  1'b0, 1'b0);
        run_op("remu_max_16", remu, 32'hFFFF_FFFF,  32'd16,         32'd15,         1'b0, 1'b0);

        // Abort: enable seen low at the tenth iteration edge.
        rdy_cnt = 0;
        @(negedge clk);
        bus.div_in.enable = 1'b1;
        bus.div_in.op     = divu;
        bus.div_in.rdata1 = 32'd100;
        bus.div_in.rdata2 = 32'd7;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.div_out.ready === 1'b1) rdy_cnt++;
            if (i == 10) bus.div_in.enable = 1'b0;
        end
        check_eq("abort_noready", 32'(rdy_cnt), 32'd0);

        run_op("divu_9_3_restart", divu, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);

        // Enable held across two operations: one ready each.
        rdy_cnt = 0;
        @(negedge clk);
        bus.div_in.enable = 1'b1;
        bus.div_in.op     = divu;
        bus.div_in.rdata1 = 32'd100;
        bus.div_in.rdata2 = 32'd7;
        for (int i = 1; i <= 67; i++) begin
            @(negedge clk);
            if (bus.div_out.ready === 1'b1) begin
                rdy_cnt++;
                check_eq("held_res", bus.div_out.result, 32'd14);
            end
        end
        @(negedge clk);
        bus.div_in.enable = 1'b0;
        check_eq("held_readies", 32'(rdy_cnt), 32'd2);

        // Reset in the middle of an operation clears outputs immediately.
        @(negedge clk);
        bus.div_in.enable = 1'b1;
        bus.div_in.op     = divu;
        bus.div_in.rdata1 = 32'd50;
        bus.div_in.rdata2 = 32'd7;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_ready",  {31'd0, bus.div_out.ready}, 32'd0);
        check_eq("midrst_result", bus.div_out.result, 32'd0);
        bus.div_in.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_50_7_post", divu, 32'd50, 32'd7, 32'd7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider that serves the execute stage's divide handshake: it accepts `div_in` (enable, op, rdata1, rdata2) and returns `div_out` (ready, result). It implements RV32M DIV/DIVU/REM/REMU, including the architectural divide-by-zero and overflow results. It sits beside the ALU and multiplier. The execute stage holds `enable` high and stalls until `ready` is seen.

## Interface
- XLEN, 32, operand/result width (package constant, not a module parameter)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- div_in  in  div_in_type  enable (1), op (div_op_type: divs, divu, rem, remu), rdata1 (dividend, XLEN), rdata2 (divisor, XLEN)
- div_out  out  div_out_type  ready (1), result (XLEN)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `enable`=1 → latch op, dividend sign, divisor sign and |rdata1|/|rdata2| (absolute values only for divs/rem; raw for divu/remu).
  - Clear the 33-bit partial remainder, load counter=XLEN-1, go to BUSY.
- BUSY, each edge (restoring step):
  - rem' = {rem[31:0], quo[31]}; quo shifted left.
  - If rem' ≥ {0,divisor}, subtract it and set quo[0]=1.
  - When counter==0, compute the final result and go to DONE; otherwise decrement the counter.
- Final result selection:
  - divs: negate the quotient if the signs differ.
  - rem: negate the remainder if the dividend is negative.
  - divu/remu: unsigned quotient/remainder.
- Special cases:
  - Divisor 0: quotient=0xFFFFFFFF (all ops), remainder=dividend. The iterative algorithm yields these naturally; signed fix-ups must be suppressed for quotient.
  - Overflow (divs/rem, dividend 0x80000000, divisor 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE:
  - `ready`=1 and `result` valid for exactly one cycle.
  - Next edge → IDLE unconditionally; `enable` is ignored in DONE because it still belongs to the retiring instruction.
- Abort: `enable`=0 while in BUSY → IDLE at the next edge, and no `ready` is issued. This covers execute clear and external stall; the execute stage re-asserts `enable` later, which restarts the operation from scratch.
- Operands are not re-sampled during BUSY; changes on rdata1/rdata2 while BUSY are ignored.

## Timing
- Reset: state=IDLE, ready=0, result=0, counter=0, internal registers 0.
- `enable` is sampled at edge E0 in IDLE; iteration edges are E1..E32; DONE (ready=1) is in the cycle after E32. Latency is 33 cycles from the accepting edge.
- `ready` and `result` are register outputs with no combinational path from `div_in`.
- Back-to-back divides: DONE→IDLE at E33, next acceptance at E34. Minimum issue interval is 34 cycles.
- Reset asserted mid-operation → immediate IDLE, ready=0, result=0.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - In IDLE with `enable`=1, divisor 0 or signed overflow goes directly to DONE with the architectural result. Ready appears the cycle after E0.
  - Divisor magnitude > dividend magnitude also goes directly to DONE, with quotient 0 and remainder = dividend, under the same signed rules.
- Undefined: every operation takes the full 33-cycle path, and special-case results come from the normal final selection.

## Structure
- Package `wires` gains:
  - div_state_type enum (IDLE, BUSY, DONE)
  - div_reg_type (state, counter, op, negq, negr, divisor, quo, rem, result, ready)
  - init_div_reg
- `wires` already holds div_in_type, div_out_type, div_op_type and init_div_op; these are unchanged.
- Single module with a comb/seq two-process style (v/r/rin); no sub-module.

## Test plan
- divu 100/7 → ready exactly in the cycle after E32, result 14; remu same operands → 2.
- divs 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); rem → 0xFFFFFFFF (-1); divs 7 / -2 → -3, rem 1.
- divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5; divs -5/0 → 0xFFFFFFFF; rem → 0xFFFFFFFB.
- divs 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
- `enable` dropped at E10 → no ready, IDLE; re-enable with divu 9/3 → result 3 after full latency; mid-BUSY rst → ready=0, result=0.
- With DIV_EARLY_OUT_EN: divu 5/0 and divu 3/10 → ready the cycle after E0, results 0xFFFFFFFF and 0; two consecutive divides with `enable` held high → exactly one ready per operation.
